shift_load_ctrl: RTL and testbench

Upstream feeder for the shift_reg stage. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It drives shift_reg's load/load_value pair: one single-cycle load pulse per word, then load held low long enough for the word to be fully shifted out. It also reports per-word completion and occupancy to the surrounding control logic.

---
 rtl/shift_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/shift_load_ctrl.sv | 126 ++++++++++++
 tb/tb_shift_load_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_reg feeder path: controller state
// encoding, shift direction names and compile-time sizing helpers.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Direction names understood by the downstream shift_reg.
    localparam string SHIFT_DIRECTION_LEFT  = "LEFT";
    localparam string SHIFT_DIRECTION_RIGHT = "RIGHT";

    // Ceiling log2 for sizing pointers and counters (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Shift cycles needed to push a whole word out of shift_reg.
    function automatic int shift_cycles(input int width, input int amount);
        return (width + amount - 1) / amount;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count. Reset and flush both empty it;
// the head word is presented combinationally on rdata.
module sync_fifo
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word storage; a write coinciding with reset or flush is dropped.
    // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/shift_load_ctrl.sv
// Feeder for shift_reg: buffers parallel words and issues one load pulse per
// word, then holds load low for the cycles needed to shift the word out.
module shift_load_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SHIFT_AMOUNT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        load,
    output logic [WIDTH-1:0]            load_value,
    output logic                        busy,
    output logic                        word_done,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int SHIFT_CYCLES = shift_cycles(WIDTH, SHIFT_AMOUNT);
    localparam int CNT_W        = clog2(SHIFT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             word_end;
    logic             pop;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Ready follows the registered count, so a pop frees space only next cycle.
    assign in_ready = !fifo_full;
    assign word_end = (state == SHIFT) && (cnt == '0);

    // Take the next word when idle or on the last shift cycle of the current one.
    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        pop = 1'b0;
        if (!flush && !fifo_empty && ((state == IDLE) || word_end)) pop = 1'b1;
    end

    // Controller FSM with shift counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            load       <= 1'b0;
            load_value <= '0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            // load_value is kept so shift_reg still sees the last loaded word.
            state     <= IDLE;
            cnt       <= '0;
            load      <= 1'b0;
            word_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    word_done <= 1'b0;
                    if (pop) begin
                        load_value <= head;
                        load       <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end else begin
                        load <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    load      <= 1'b0;
                    cnt       <= CNT_START;
                    // With a single shift cycle the first SHIFT cycle is also the last.
                    word_done <= (SHIFT_CYCLES == 1);
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        word_done <= 1'b0;
                        if (pop) begin
                            load_value <= head;
                            load       <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt       <= cnt - 1'b1;
                        word_done <= (cnt == CNT_LAST);
                    end
                end
                default: begin
                    load      <= 1'b0;
                    word_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: three instances (SHIFT_AMOUNT 1, 3, 8) share one
// directed stimulus stream. A transaction-level model (word queue plus the
// position inside the current word window) predicts every output each cycle;
// directed checks pin load timing, spacing and values with literal numbers.
module tb_shift_load_ctrl;

    localparam int N     = 3;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       flush    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;

    logic       in_ready_o  [N];
    logic       load_o      [N];
    logic [7:0] lv_o        [N];
    logic       busy_o      [N];
    logic       word_done_o [N];
    logic [2:0] count_o     [N];

    shift_load_ctrl #(.WIDTH(8), .SHIFT_AMOUNT(1), .FIFO_DEPTH(DEPTH)) dut_sa1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .in_data(in_data), .load(load_o[0]), .load_value(lv_o[0]), .busy(busy_o[0]),
        .word_done(word_done_o[0]), .fifo_count(count_o[0]));

    shift_load_ctrl #(.WIDTH(8), .SHIFT_AMOUNT(3), .FIFO_DEPTH(DEPTH)) dut_sa3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .in_data(in_data), .load(load_o[1]), .load_value(lv_o[1]), .busy(busy_o[1]),
        .word_done(word_done_o[1]), .fifo_count(count_o[1]));

    shift_load_ctrl #(.WIDTH(8), .SHIFT_AMOUNT(8), .FIFO_DEPTH(DEPTH)) dut_sa8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .in_data(in_data), .load(load_o[2]), .load_value(lv_o[2]), .busy(busy_o[2]),
        .word_done(word_done_o[2]), .fifo_count(count_o[2]));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit model_valid = 1'b0;
    bit ready_low_seen = 1'b0;

    // Model: words waiting, position in the current word window
    // (-1 idle, 0 load cycle, 1..sc shift cycles), last loaded word.
    logic [7:0] mq  [N][$];
    int         pos [N];
    int         sc  [N];
    logic [7:0] lv  [N];
    bit         accept;

    // Observed load / word_done events for the directed checks.
    int         ld_cyc [N][$];
    logic [7:0] ld_val [N][$];
    int         wd_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model update on each rising edge from the (stable) inputs.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mq[i].delete();
                pos[i] = -1;
                lv[i]  = 8'h00;
            end else if (flush) begin
                mq[i].delete();
                pos[i] = -1;
            end else begin
                accept = in_valid && (mq[i].size() < DEPTH);
                if (pos[i] == -1 || pos[i] == sc[i]) begin
                    if (mq[i].size() > 0) begin
                        lv[i]  = mq[i].pop_front();
                        pos[i] = 0;
                    end else begin
                        pos[i] = -1;
                    end
                end else begin
                    pos[i]++;
                end
                if (accept) mq[i].push_back(in_data);
            end
        end
        if (rst) model_valid = 1'b1;
    end

    // Compare every output of every instance on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("load[%0d]", i),       load_o[i],      (pos[i] == 0));
                check($sformatf("load_value[%0d]", i), lv_o[i],        lv[i]);
                check($sformatf("busy[%0d]", i),       busy_o[i],      (pos[i] >= 0));
                check($sformatf("word_done[%0d]", i),  word_done_o[i], (pos[i] == sc[i]));
                check($sformatf("fifo_count[%0d]", i), count_o[i],     mq[i].size());
                check($sformatf("in_ready[%0d]", i),   in_ready_o[i],  (mq[i].size() < DEPTH));
                if (load_o[i]) begin
                    ld_cyc[i].push_back(cyc);
                    ld_val[i].push_back(lv_o[i]);
                end
            end
            if (word_done_o[0]) wd_cyc.push_back(cyc);
            if (count_o[0] == 3'd4 && !in_ready_o[0]) ready_low_seen = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < N; i++) begin
            ld_cyc[i].delete();
            ld_val[i].delete();
        end
        wd_cyc.delete();
    endtask

    // One-cycle push without handshake; returns the edge index of the push.
    task automatic push(input logic [7:0] w, output int k);
        in_valid = 1'b1;
        in_data  = w;
        step();
        k        = cyc;
        in_valid = 1'b0;
    endtask

    // Push that holds the word until dut_sa1 is ready, with a bounded wait.
    task automatic push_hs(input logic [7:0] w);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready_o[0] && waited < 200) begin
            step();
            waited++;
        end
        if (waited >= 200) check("handshake_timeout", in_ready_o[0], 1);
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] full_words [6];
    int k0;
    int k1;

    initial begin
        sc[0] = 8;   // ceil(8/1)
        sc[1] = 3;   // ceil(8/3)
        sc[2] = 1;   // ceil(8/8)
        for (int i = 0; i < N; i++) pos[i] = -1;
        full_words = '{8'hC1, 8'hD2, 8'hE3, 8'hF4, 8'h05, 8'h16};

        // Reset held 5 cycles with a valid word presented.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        idle(5);
        check("reset_load", load_o[0], 0);
        check("reset_count", count_o[0], 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        check("ready_after_rst", in_ready_o[0], 1);
        check("lv_after_rst", lv_o[0], 8'h00);

        // Single word.
        clear_logs();
        push(8'h09, k0);
        idle(14);
        check("single_load_count", ld_cyc[0].size(), 1);
        check("single_load_cycle", ld_cyc[0][0], k0 + 1);
        check("single_load_value", ld_val[0][0], 8'h09);
        check("single_done_count", wd_cyc.size(), 1);
        check("single_done_cycle", wd_cyc[0], k0 + 9);
        check("single_busy_end", busy_o[0], 0);

        // Back-to-back words.
        clear_logs();
        push(8'hA5, k0);
        push(8'h3C, k1);
        push(8'hF0, k1);
        idle(40);
        check("b2b_load_count", ld_cyc[0].size(), 3);
        check("b2b_first_cycle", ld_cyc[0][0], k0 + 1);
        check("b2b_gap01", ld_cyc[0][1] - ld_cyc[0][0], 9);
        check("b2b_gap12", ld_cyc[0][2] - ld_cyc[0][1], 9);
        check("b2b_val0", ld_val[0][0], 8'hA5);
        check("b2b_val1", ld_val[0][1], 8'h3C);
        check("b2b_val2", ld_val[0][2], 8'hF0);
        check("b2b_done_count", wd_cyc.size(), 3);
        check("sa3_gap01", ld_cyc[1][1] - ld_cyc[1][0], 4);
        check("sa3_gap12", ld_cyc[1][2] - ld_cyc[1][1], 4);
        check("sa8_gap01", ld_cyc[2][1] - ld_cyc[2][0], 2);
        check("sa8_gap12", ld_cyc[2][2] - ld_cyc[2][1], 2);
        check("sa8_val2", ld_val[2][2], 8'hF0);

        // Backpressure: six words while busy.
        clear_logs();
        ready_low_seen = 1'b0;
        for (int i = 0; i < 6; i++) push_hs(full_words[i]);
        idle(80);
        check("full_ready_dropped", ready_low_seen, 1);
        check("full_load_count", ld_cyc[0].size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("full_order%0d", i), ld_val[0][i], full_words[i]);
        end

        // Flush mid-SHIFT with three words queued.
        clear_logs();
        push(8'h11, k0);
        push(8'h22, k1);
        push(8'h33, k1);
        push(8'h44, k1);
        idle(3);
        check("pre_flush_count", count_o[0], 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", count_o[0], 0);
        check("flush_busy", busy_o[0], 0);
        check("flush_load", load_o[0], 0);
        check("flush_lv_kept", lv_o[0], 8'h11);
        clear_logs();
        idle(20);
        check("flush_no_loads", ld_cyc[0].size(), 0);
        check("flush_count_end", count_o[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
